// File: rtl/video_capture_cntrlr_if.sv
// Local-bus register port and system-memory write port of the video capture controller.
// slave is the controller's view; master is the host/memory side.
interface video_capture_cntrlr_if #(
   parameter int LB_DATA_W      = 32,
   parameter int LB_ADDR_W      = 8,
   parameter int SYS_MEM_DATA_W = 32,
   parameter int SYS_MEM_ADDR_W = 27
);
   logic                      lb_wr_en;
   logic                      lb_rd_en;
   logic [LB_ADDR_W-1:0]      lb_addr;
   logic [LB_DATA_W-1:0]      lb_wr_data;
   logic                      lb_wr_valid;
   logic                      lb_rd_valid;
   logic [LB_DATA_W-1:0]      lb_rd_data;
   logic                      sys_mem_wait;
   logic                      sys_mem_wren;
   logic                      sys_mem_rden;
   logic [SYS_MEM_ADDR_W-1:0] sys_mem_addr;
   logic [SYS_MEM_DATA_W-1:0] sys_mem_wdata;
   logic                      sys_mem_rd_valid;
   logic [SYS_MEM_DATA_W-1:0] sys_mem_rdata;

   modport slave (
      input  lb_wr_en, lb_rd_en, lb_addr, lb_wr_data,
      input  sys_mem_wait, sys_mem_rd_valid, sys_mem_rdata,
      output lb_wr_valid, lb_rd_valid, lb_rd_data,
      output sys_mem_wren, sys_mem_rden, sys_mem_addr, sys_mem_wdata
   );

   modport master (
      output lb_wr_en, lb_rd_en, lb_addr, lb_wr_data,
      output sys_mem_wait, sys_mem_rd_valid, sys_mem_rdata,
      input  lb_wr_valid, lb_rd_valid, lb_rd_data,
      input  sys_mem_wren, sys_mem_rden, sys_mem_addr, sys_mem_wdata
   );
endinterface

// File: rtl/video_capture_cntrlr.sv
// Parallel RGB video receiver: captures DE pixels into a small FIFO and writes them,
// one frame at a time, as 32-bit words into system memory; local-bus CSRs for control/status.
module video_capture_cntrlr #(
   parameter int                   LB_DATA_W              = 32,
   parameter int                   LB_ADDR_W              = 8,
   parameter int                   SYS_MEM_DATA_W         = 32,
   parameter int                   SYS_MEM_ADDR_W         = 27,
   parameter int                   SYS_MEM_START_ADDR     = 0,
   parameter int                   SYS_MEM_STOP_ADDR      = 921599,
   parameter int                   FIFO_DEPTH             = 16,
   parameter bit                   SYNC_ACTIVE_HIGH_N_LOW = 1'b0,
   parameter logic [LB_DATA_W-1:0] DEFAULT_REG_VAL        = 32'hdeadbabe
) (
   input  logic                        clk,
   input  logic                        rst_n,
   video_capture_cntrlr_if.slave       bus,
   input  logic [23:0]                 vid_d,
   input  logic                        vid_de,
   input  logic                        vid_hs,
   input  logic                        vid_vs
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [SYS_MEM_ADDR_W:0] START_L = (SYS_MEM_ADDR_W+1)'(SYS_MEM_START_ADDR);
   localparam logic [SYS_MEM_ADDR_W:0] STOP_L  = (SYS_MEM_ADDR_W+1)'(SYS_MEM_STOP_ADDR);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT_VS = 2'd1, ST_CAPTURE = 2'd2, ST_DRAIN = 2'd3} state_t;

   state_t state_q, state_d;
   logic [23:0] vid_d_q;
   logic vid_de_q, de_prev_q, vid_vs_q, vs_prev_q, vid_hs_q;
   logic sof_q, sof_d, cap_en_q, cap_en_d, single_q, single_d;
   logic ovrflw_q, ovrflw_d, frame_done_q, frame_done_d, oversize_q, oversize_d;
   logic [15:0] line_len_q, line_len_d, last_len_q, last_len_d, line_cnt_q, line_cnt_d;
   logic [15:0] hres_q, hres_d, vres_q, vres_d;
   logic [31:0] frame_cnt_q, frame_cnt_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic wren_q, wren_d;
   logic [SYS_MEM_ADDR_W-1:0] addr_q, addr_d;
   logic [SYS_MEM_DATA_W-1:0] wdata_q, wdata_d;
   logic wr_valid_q, rd_valid_q;
   logic [LB_DATA_W-1:0] rd_data_q, rd_data_d;
   logic [24:0] fifo_mem_q [FIFO_DEPTH];

   logic vs_edge_s, de_fall_s, push_req_s, push_ok_s, pop_s, ovf_set_s, frame_evt_s;
   logic fifo_empty_s, fifo_full_s, oversize_set_s, busy_s, cfg_wr_s, sts_wr_s;
   logic [2:0] clr_s;
   logic [24:0] rd_word_s;
   logic [SYS_MEM_ADDR_W:0] next_addr_s;
   logic unused_s;

   // Active VS level per polarity; an edge is inactive -> active on the registered input.
   assign vs_edge_s    = SYNC_ACTIVE_HIGH_N_LOW ? (vid_vs_q & ~vs_prev_q) : (~vid_vs_q & vs_prev_q);
   assign de_fall_s    = de_prev_q & ~vid_de_q;
   assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
   assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_s        = !fifo_empty_s && (!wren_q || !bus.sys_mem_wait);
   assign push_ok_s    = push_req_s && (!fifo_full_s || pop_s);
   assign ovf_set_s    = push_req_s && fifo_full_s && !pop_s;
   assign rd_word_s    = fifo_mem_q[rd_ptr_q[AW-1:0]];
   assign busy_s       = (state_q != ST_IDLE);
   assign unused_s     = ^{bus.sys_mem_rd_valid, bus.sys_mem_rdata, bus.lb_wr_data[LB_DATA_W-1:3], vid_hs_q};

   // Capture FSM: frame sequencing, SOF arming and push requests.
   always_comb begin
      state_d     = state_q;
      sof_d       = sof_q;
      push_req_s  = 1'b0;
      frame_evt_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cap_en_q) state_d = ST_WAIT_VS;
            else          state_d = ST_IDLE;
         end
         ST_WAIT_VS: begin
            if (!cap_en_q) begin
               state_d = ST_IDLE;
            end else if (vs_edge_s) begin
               state_d = ST_CAPTURE;
               sof_d   = 1'b1;
            end else begin
               state_d = ST_WAIT_VS;
            end
         end
         ST_CAPTURE: begin
            if (vs_edge_s) begin
               frame_evt_s = 1'b1;
               if (single_q || !cap_en_q) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_CAPTURE;
                  sof_d   = 1'b1;
               end
            end else if (!cap_en_q) begin
               state_d = ST_DRAIN;
            end else begin
               push_req_s = vid_de_q;
               if (vid_de_q && (!fifo_full_s || pop_s)) sof_d = 1'b0;
               else                                     sof_d = sof_q;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty_s && !wren_q) state_d = ST_IDLE;
            else                         state_d = ST_DRAIN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FIFO pointers and memory writer; outputs hold while the memory stalls.
   always_comb begin
      wr_ptr_d       = wr_ptr_q + (push_ok_s ? (AW+1)'(1) : (AW+1)'(0));
      rd_ptr_d       = rd_ptr_q + (pop_s ? (AW+1)'(1) : (AW+1)'(0));
      wren_d         = wren_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      oversize_set_s = 1'b0;
      next_addr_s    = rd_word_s[24] ? START_L : ({1'b0, addr_q} + (SYS_MEM_ADDR_W+1)'(1));
      if (pop_s) begin
         if (next_addr_s > STOP_L) begin
            wren_d         = 1'b0;
            oversize_set_s = 1'b1;
         end else begin
            wren_d  = 1'b1;
            addr_d  = next_addr_s[SYS_MEM_ADDR_W-1:0];
            wdata_d = SYS_MEM_DATA_W'({8'h00, rd_word_s[23:0]});
         end
      end else if (!bus.sys_mem_wait) begin
         wren_d = 1'b0;
      end else begin
         wren_d = wren_q;
      end
   end

   // Resolution/frame measurement and CSR next state; sticky sets beat write-1-to-clear.
   always_comb begin
      last_len_d  = last_len_q;
      hres_d      = hres_q;
      vres_d      = vres_q;
      frame_cnt_d = frame_cnt_q;
      if (de_fall_s) begin
         last_len_d = line_len_q;
         line_len_d = 16'd0;
      end else if (vid_de_q && (line_len_q != 16'hFFFF)) begin
         line_len_d = line_len_q + 16'd1;
      end else begin
         line_len_d = line_len_q;
      end
      if (vs_edge_s)                                     line_cnt_d = 16'd0;
      else if (de_fall_s && (line_cnt_q != 16'hFFFF))    line_cnt_d = line_cnt_q + 16'd1;
      else                                               line_cnt_d = line_cnt_q;
      if (frame_evt_s) begin
         frame_cnt_d = frame_cnt_q + 32'd1;
         hres_d      = last_len_q;
         vres_d      = line_cnt_q;
      end else begin
         frame_cnt_d = frame_cnt_q;
      end
      cfg_wr_s = bus.lb_wr_en && (bus.lb_addr == LB_ADDR_W'(0));
      sts_wr_s = bus.lb_wr_en && (bus.lb_addr == LB_ADDR_W'(1));
      clr_s    = sts_wr_s ? bus.lb_wr_data[2:0] : 3'b000;
      if (cfg_wr_s) begin
         cap_en_d = bus.lb_wr_data[0];
         single_d = bus.lb_wr_data[1];
      end else begin
         cap_en_d = cap_en_q;
         single_d = single_q;
      end
      ovrflw_d     = (ovrflw_q & ~clr_s[0]) | ovf_set_s;
      frame_done_d = (frame_done_q & ~clr_s[1]) | frame_evt_s;
      oversize_d   = (oversize_q & ~clr_s[2]) | oversize_set_s;
      rd_data_d    = LB_DATA_W'(0);
      if (bus.lb_rd_en) begin
         case (bus.lb_addr)
            LB_ADDR_W'(0): rd_data_d = LB_DATA_W'({single_q, cap_en_q});
            LB_ADDR_W'(1): rd_data_d = LB_DATA_W'({busy_s, oversize_q, frame_done_q, ovrflw_q});
            LB_ADDR_W'(2): rd_data_d = LB_DATA_W'(hres_q);
            LB_ADDR_W'(3): rd_data_d = LB_DATA_W'(vres_q);
            LB_ADDR_W'(4): rd_data_d = LB_DATA_W'(frame_cnt_q);
            default:       rd_data_d = DEFAULT_REG_VAL;
         endcase
      end else begin
         rd_data_d = LB_DATA_W'(0);
      end
   end

   // Pixel FIFO storage; emptiness is tracked by the reset pointers.
   always_ff @(posedge clk) begin
      if (push_ok_s) fifo_mem_q[wr_ptr_q[AW-1:0]] <= {sof_q, vid_d_q};
   end

   // State registers, including the single input-register stage for the video bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;        vid_d_q <= 24'd0;
         vid_de_q <= 1'b0;          de_prev_q <= 1'b0;
         vid_vs_q <= 1'b0;          vs_prev_q <= 1'b0;          vid_hs_q <= 1'b0;
         sof_q <= 1'b0;             cap_en_q <= 1'b0;           single_q <= 1'b0;
         ovrflw_q <= 1'b0;          frame_done_q <= 1'b0;       oversize_q <= 1'b0;
         line_len_q <= 16'd0;       last_len_q <= 16'd0;        line_cnt_q <= 16'd0;
         hres_q <= 16'd0;           vres_q <= 16'd0;            frame_cnt_q <= 32'd0;
         wr_ptr_q <= (AW+1)'(0);    rd_ptr_q <= (AW+1)'(0);
         wren_q <= 1'b0;            addr_q <= SYS_MEM_ADDR_W'(0); wdata_q <= SYS_MEM_DATA_W'(0);
         wr_valid_q <= 1'b0;        rd_valid_q <= 1'b0;         rd_data_q <= LB_DATA_W'(0);
      end else begin
         state_q <= state_d;        vid_d_q <= vid_d;
         vid_de_q <= vid_de;        de_prev_q <= vid_de_q;
         vid_vs_q <= vid_vs;        vs_prev_q <= vid_vs_q;      vid_hs_q <= vid_hs;
         sof_q <= sof_d;            cap_en_q <= cap_en_d;       single_q <= single_d;
         ovrflw_q <= ovrflw_d;      frame_done_q <= frame_done_d; oversize_q <= oversize_d;
         line_len_q <= line_len_d;  last_len_q <= last_len_d;   line_cnt_q <= line_cnt_d;
         hres_q <= hres_d;          vres_q <= vres_d;           frame_cnt_q <= frame_cnt_d;
         wr_ptr_q <= wr_ptr_d;      rd_ptr_q <= rd_ptr_d;
         wren_q <= wren_d;          addr_q <= addr_d;           wdata_q <= wdata_d;
         wr_valid_q <= bus.lb_wr_en; rd_valid_q <= bus.lb_rd_en; rd_data_q <= rd_data_d;
      end
   end

   assign bus.lb_wr_valid   = wr_valid_q;
   assign bus.lb_rd_valid   = rd_valid_q;
   assign bus.lb_rd_data    = rd_data_q;
   assign bus.sys_mem_wren  = wren_q;
   assign bus.sys_mem_rden  = 1'b0;
   assign bus.sys_mem_addr  = addr_q;
   assign bus.sys_mem_wdata = wdata_q;
endmodule

// File: doc/video_capture_cntrlr.md
Name: video_capture_cntrlr

Overview:
- Receive side of the parallel 24-bit RGB video interface (D/DE/HS/VS): the inverse of the HDMI TX path.
- Samples incoming active pixels and buffers them in a small FIFO. Writes them as 32-bit words into system memory, one frame at a time, from SYS_MEM_START_ADDR upward.
- Controlled and monitored through the standard local-bus register interface.
- Measured resolution and frame counters support link bring-up.

Parameters:
- LB_DATA_W, 32, local bus data width
- LB_ADDR_W, 8, local bus address width
- SYS_MEM_DATA_W, 32, memory data width; pixel zero-extended {8'h00,R,G,B}
- SYS_MEM_ADDR_W, 27, memory word address width
- SYS_MEM_START_ADDR, 0, word address of pixel 0 of every frame
- SYS_MEM_STOP_ADDR, 921599, last writable word address
- FIFO_DEPTH, 16, pixel FIFO entries (power of 2)
- SYNC_ACTIVE_HIGH_N_LOW, 0, 1 = HS/VS active high, 0 = active low
- DEFAULT_REG_VAL, 'hdeadbabe, read data for unmapped addresses

Ports:
- clk  in  1  system and pixel clock; video inputs are synchronous to clk
- rst_n  in  1  asynchronous, active-low reset
- lb_wr_en  in  1  register write strobe
- lb_rd_en  in  1  register read strobe
- lb_addr  in  LB_ADDR_W  register address
- lb_wr_data  in  LB_DATA_W  write data
- lb_wr_valid  out  1  write ack, 1 cycle after lb_wr_en
- lb_rd_valid  out  1  read ack, 1 cycle after lb_rd_en
- lb_rd_data  out  LB_DATA_W  read data, valid with lb_rd_valid
- sys_mem_wait  in  1  memory backpressure
- sys_mem_wren  out  1  write request
- sys_mem_rden  out  1  tied 0
- sys_mem_addr  out  SYS_MEM_ADDR_W  write address
- sys_mem_wdata  out  SYS_MEM_DATA_W  write data
- sys_mem_rd_valid  in  1  unused
- sys_mem_rdata  in  SYS_MEM_DATA_W  unused
- vid_d  in  24  pixel data {R,G,B}
- vid_de  in  1  data enable
- vid_hs  in  1  horizontal sync
- vid_vs  in  1  vertical sync

Behaviour:
- Reset:
  - All outputs are 0, all registers are 0, FSM is IDLE, FIFO is empty.
  - Reset is asynchronous and abandons any in-flight write.
- Register map (word addresses):
  - 0x00 CONFIG: [0] cap_en, [1] single_frame. R/W.
  - 0x01 STATUS: [0] ovrflw, [1] frame_done, [2] oversize, all sticky and write-1-to-clear; [3] busy (FSM != IDLE), read-only.
  - 0x02 HRES: [15:0] DE pixels in last line of last completed frame.
  - 0x03 VRES: [15:0] DE lines in last completed frame.
  - 0x04 FRAME_CNT: [31:0] completed frames, wraps.
  - Any other address reads DEFAULT_REG_VAL. Writes to read-only or unmapped addresses are ignored.
- Input path:
  - All vid_* inputs are registered once.
  - VS active edge = transition into the asserted level per SYNC_ACTIVE_HIGH_N_LOW.
  - DE fall = registered DE 1 -> 0.
- FSM:
  - IDLE: if cap_en=1, go to WAIT_VS.
  - WAIT_VS: on VS active edge, go to CAPTURE and arm the SOF flag. If cap_en=0, go to IDLE.
  - CAPTURE:
    - Each registered DE=1 cycle pushes {sof,pixel} (25 bits); sof clears after the first push.
    - On VS active edge: FRAME_CNT+1, latch HRES/VRES, set frame_done. Then, if single_frame=1 or cap_en=0, go to DRAIN; else re-arm SOF and stay in CAPTURE.
    - If cap_en cleared mid-frame: go to DRAIN immediately, stop pushing, leave counters unchanged.
  - DRAIN: go to IDLE when the FIFO is empty and sys_mem_wren=0.
- Measurement:
  - line_len counts DE cycles and is zeroed on DE fall.
  - line count increments on DE fall and is zeroed at VS edge.
  - HRES takes the last completed line_len; both counters saturate at 16'hFFFF.
- FIFO:
  - Push when full: pixel is dropped, ovrflw is set, FIFO contents are unaffected.
  - Simultaneous push and pop when full is allowed; no drop.
- Writer:
  - Pops when FIFO is non-empty and (sys_mem_wren=0 or sys_mem_wait=0).
  - A popped word with sof=1 writes at SYS_MEM_START_ADDR. Otherwise the address is previous+1.
  - While sys_mem_wait=1, wren, addr and wdata are held stable.
  - If the next address would exceed SYS_MEM_STOP_ADDR, the word is discarded (no wren) and oversize is set.
  - Latency: vid_de in cycle N produces sys_mem_wren no earlier than N+3 with wait=0.
- Simultaneous events:
  - Sticky-bit set has priority over a same-cycle write-1-to-clear.
  - Read and write in the same cycle both complete.

Test Plan:
- Basic capture: cap_en=1, single_frame=1; 4 lines x 8 pixels, pixel value = index, wait=0. Expect 32 writes to addr 0..31 with wdata 0..31, HRES=8, VRES=4, FRAME_CNT=1, frame_done=1, then busy=0.
- Backpressure: same frame with sys_mem_wait toggling 1/0 every 2 cycles. Expect addr/wdata stable during wait, 32 writes in order, ovrflw=0.
- Overflow: FIFO_DEPTH=16, wait=1 held across a 40-pixel line. Expect ovrflw=1 and the 17 oldest pixels written after wait releases; clearing STATUS with 0x1 reads back 0.
- Continuous mode: cap_en=1, single_frame=0; 3 frames of 2x4 pixels. Expect each frame written at addr 0..7, FRAME_CNT=3. After clearing cap_en, the FSM drains to IDLE.
- Oversize: STOP_ADDR=9 with a 16-pixel frame. Expect writes to addr 0..9 only and oversize=1.
- Register bus: read 0x10 returns 0xdeadbabe; write CONFIG=0x3 reads back 0x3; an asynchronous rst_n pulse mid-CAPTURE returns all registers and outputs to 0.
